pixel_sink: RTL and testbench

PIXEL_SINK -- requirements
Module: pixel_sink

---
 rtl/pixel_pkg.sv | 30 +++
 rtl/pixel_fifo.sv | 61 ++++++
 rtl/pixel_sink.sv | 100 ++++++++++
 tb/tb_pixel_sink.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared constants, pixel entry type and drain FSM states for pixel_sink
package pixel_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = 15;
    localparam int PTR_W      = 3;
    localparam int CNT_W      = 4;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // y*160 + x as two shifts and adds, widened first so nothing is truncated
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
        logic [ADDR_W-1:0] yw;
        yw = {8'b0, y};
        return (yw << 7) + (yw << 5) + {7'b0, x};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - 8-entry pixel FIFO with registered full/empty from an occupancy count
module pixel_fifo
    import pixel_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  pixel_t wr_data,
    output pixel_t rd_data,
    output logic   full,
    output logic   empty
);

    pixel_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Occupancy moves by at most one; push and pop together cancel out
    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (do_pop && !do_push)
            count_next = count - 1'b1;
    end

    // Storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at 8; flags are registered from the next occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CNT_W'(FIFO_DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/pixel_sink.sv
// rtl/pixel_sink.sv - buffers drawer pixels and drains them to a framebuffer; optional PIXEL_SINK_CLIP_EN drops off-screen pixels
module pixel_sink
    import pixel_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        x_in,
    input  logic [6:0]        y_in,
    input  logic [2:0]        colour_in,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic [7:0]        drop_count
);

    state_t     state;
    pixel_t     head;
    pixel_t     hold;
    pixel_t     wr_pixel;
    logic       pop;
    logic       head_clip;
    logic       overflow_drop;
    logic       clip_drop;
    logic [8:0] drop_sum;

    assign wr_pixel = '{x: x_in, y: y_in, colour: colour_in};
    assign pop      = (state == S_IDLE) && !empty;

`ifdef PIXEL_SINK_CLIP_EN
    assign head_clip = (head.x >= 8'(SCREEN_W)) || (head.y >= 7'(SCREEN_H));
`else
    assign head_clip = 1'b0;
`endif

    assign overflow_drop = wr_en && full;
    assign clip_drop     = pop && head_clip;
    assign drop_sum      = {1'b0, drop_count} + {8'b0, overflow_drop} + {8'b0, clip_drop};

    pixel_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_pixel),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Drain FSM: pop into hold, compute address, then hold the write until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            hold    <= '0;
            fb_addr <= '0;
            fb_data <= '0;
            fb_we   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop && !head_clip) begin
                        hold  <= head;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    fb_addr <= pixel_addr(hold.x, hold.y);
                    fb_data <= hold.colour;
                    fb_we   <= 1'b1;
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (fb_ready) begin
                        fb_we <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    fb_we <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Discarded-pixel counter; overflow and clip drops may coincide, so it can step by 2
    always_ff @(posedge clk) begin
        if (reset)
            drop_count <= '0;
        else if (drop_sum > 9'd255)
            drop_count <= 8'd255;
        else
            drop_count <= drop_sum[7:0];
    end

endmodule

// File: tb/tb_pixel_sink.sv
// tb/tb_pixel_sink.sv - scoreboard bench for pixel_sink
module tb_pixel_sink;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [7:0]  x_in;
    logic [6:0]  y_in;
    logic [2:0]  colour_in;
    logic        full;
    logic        empty;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;
    int exp_addr [$];
    int exp_data [$];

    pixel_sink dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .full       (full),
        .empty      (empty),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .fb_ready   (fb_ready),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted framebuffer write must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && fb_we && fb_ready) begin
            if (exp_addr.size() == 0) begin
                chk("unexpected_write_addr", int'(fb_addr), -1);
            end else begin
                chk("write_addr", int'(fb_addr), exp_addr.pop_front());
                chk("write_data", int'(fb_data), exp_data.pop_front());
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic push(input int x, input int y, input int c, input bit expect_write);
        x_in      = 8'(x);
        y_in      = 7'(y);
        colour_in = 3'(c);
        wr_en     = 1'b1;
        if (expect_write) begin
            exp_addr.push_back(y * 160 + x);
            exp_data.push_back(c);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic wait_we(input int limit);
        for (int i = 0; i < limit && !fb_we; i++) begin
            @(posedge clk); #1;
        end
        chk("wait_fb_we", int'(fb_we), 1);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && !(exp_addr.size() == 0 && empty && !fb_we); i++) begin
            @(posedge clk); #1;
        end
        chk("drain_pending", exp_addr.size(), 0);
        chk("drain_empty", int'(empty), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        x_in      = '0;
        y_in      = '0;
        colour_in = '0;
        fb_ready  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_data", int'(fb_data), 0);
        chk("rst_drop", int'(drop_count), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single pixel latency: push at edge N, fb_we after edge N+2
        fb_ready = 1'b1;
        push(5, 2, 3, 1'b1);
        chk("single_we_after_n", int'(fb_we), 0);
        @(posedge clk); #1;
        chk("single_we_after_n1", int'(fb_we), 0);
        @(posedge clk); #1;
        chk("single_we_after_n2", int'(fb_we), 1);
        chk("single_addr", int'(fb_addr), 325);
        chk("single_data", int'(fb_data), 3);
        @(posedge clk); #1;
        chk("single_we_done", int'(fb_we), 0);
        chk("single_empty", int'(empty), 1);
        chk("single_pending", exp_addr.size(), 0);

        // Overflow: stall the drain on a primer pixel, then push 10
        do_reset();
        fb_ready = 1'b0;
        push(1, 1, 1, 1'b1);
        wait_we(10);
        for (int i = 0; i < 10; i++) begin
            x_in      = 8'(10 + i);
            y_in      = 7'(i);
            colour_in = 3'(i);
            wr_en     = 1'b1;
            if (i < 8) begin
                exp_addr.push_back(i * 160 + 10 + i);
                exp_data.push_back(i % 8);
            end
            @(posedge clk); #1;
            if (i == 6) chk("ovf_full_after7", int'(full), 0);
            if (i == 7) chk("ovf_full_after8", int'(full), 1);
        end
        wr_en = 1'b0;
        chk("ovf_drop", int'(drop_count), 2);
        fb_ready = 1'b1;
        drain(100);
        chk("ovf_full_cleared", int'(full), 0);

        // Backpressure: write held for 5 cycles, completes when fb_ready rises
        do_reset();
        fb_ready = 1'b0;
        push(20, 3, 5, 1'b1);
        wait_we(10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_we_held", int'(fb_we), 1);
            chk("bp_addr_held", int'(fb_addr), 500);
            chk("bp_data_held", int'(fb_data), 5);
            @(posedge clk); #1;
        end
        fb_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_we_released", int'(fb_we), 0);
        chk("bp_pending", exp_addr.size(), 0);

        // Clip behaviour on off-screen and corner pixels
        do_reset();
        fb_ready = 1'b1;
`ifdef PIXEL_SINK_CLIP_EN
        push(200, 10, 2, 1'b0);
`else
        push(200, 10, 2, 1'b1);
`endif
        push(159, 119, 6, 1'b1);
        drain(100);
`ifdef PIXEL_SINK_CLIP_EN
        chk("clip_drop", int'(drop_count), 1);
`else
        chk("clip_drop", int'(drop_count), 0);
`endif

        // Reset mid-stream: one pixel in S_WRITE, 4 buffered
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(30 + i, 4, i, 1'b0);
        wait_we(10);
        chk("mid_not_empty", int'(empty), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_we", int'(fb_we), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_drop", int'(drop_count), 0);
        reset = 1'b0;
        fb_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_post_empty", int'(empty), 1);
        chk("mid_post_we", int'(fb_we), 0);

        // Saturation: 300 overflow drops
        do_reset();
        fb_ready = 1'b0;
        push(0, 0, 0, 1'b0);
        wait_we(10);
        x_in  = 8'd7;
        y_in  = 7'd7;
        wr_en = 1'b1;
        for (int i = 0; i < 308; i++) begin
            @(posedge clk); #1;
            if (i == 207) chk("sat_drop_200", int'(drop_count), 200);
        end
        wr_en = 1'b0;
        chk("sat_drop_255", int'(drop_count), 255);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
